// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// (aligned with the ALU op codes) and FSM states.
package muldiv_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Mul/div ops occupy encodings 0..3.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   acc,
    input  logic [XLEN-1:0] work,
    input  logic [XLEN-1:0] opnd,
    input  logic            is_div,
    output logic [XLEN:0]   acc_next,
    output logic            q_bit
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    assign sum     = acc + {1'b0, (work[0] ? opnd : {XLEN{1'b0}})};
    assign shifted = {acc[XLEN-1:0], work[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, opnd};

    always_comb begin
        acc_next = '0;
        q_bit    = 1'b0;
        if (is_div) begin
            q_bit    = ~diff[XLEN+1];
            acc_next = q_bit ? diff[XLEN:0] : shifted;
        end else begin
            // Low bit of the sum falls into the top of the product's low half.
            acc_next = {1'b0, sum[XLEN:1]};
            q_bit    = sum[0];
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide controller with fixed 34-cycle latency,
// single-cycle MTHI/MTLO, flush and synchronous reset.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   acc, acc_next;
    logic [XLEN-1:0] work, opnd, rs_q, rt_q;
    logic [2:0]      op_q;
    logic            neg_q, rneg_q, div0_q, q_bit;
    logic            accept, launch, is_div;

    assign accept = (state == ST_IDLE) && start && !flush;
    assign launch = accept && is_muldiv(op);
    assign is_div = op_q[1];

    muldiv_step #(.XLEN(XLEN)) u_step (
        .acc      (acc),
        .work     (work),
        .opnd     (opnd),
        .is_div   (is_div),
        .acc_next (acc_next),
        .q_bit    (q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch) state_next = ST_PREP;
            ST_PREP: state_next = ST_ITER;
            ST_ITER: if (cnt == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush && state != ST_IDLE) state_next = ST_IDLE;
    end

    // Outputs
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Operand magnitudes and result signs, evaluated in PREP
    logic            sgn, rs_neg, rt_neg;
    logic [XLEN-1:0] rs_abs, rt_abs;

    always_comb begin
        sgn    = !op_q[0];
        rs_neg = sgn && rs_q[XLEN-1];
        rt_neg = sgn && rt_q[XLEN-1];
        rs_abs = rs_neg ? (~rs_q + 1'b1) : rs_q;
        rt_abs = rt_neg ? (~rt_q + 1'b1) : rt_q;
    end

    // Sign fixup for the result written on FIX exit
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_hi, res_lo, quo, rem;

    always_comb begin
        prod   = {acc[XLEN-1:0], work};
        if (neg_q) prod = ~prod + 1'b1;
        quo    = neg_q  ? (~work + 1'b1) : work;
        rem    = rneg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        res_hi = prod[2*XLEN-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (is_div) begin
            res_hi = div0_q ? rs_q : rem;
            res_lo = div0_q ? {XLEN{1'b1}} : quo;
        end
    end

    // Working registers: never observable outside a run, so not reset.
    always_ff @(posedge clk) begin
        if (launch) begin
            rs_q <= rs_val;
            rt_q <= rt_val;
            op_q <= op;
        end
        case (state)
            ST_PREP: begin
                acc    <= '0;
                work   <= op_q[1] ? rs_abs : rt_abs;
                opnd   <= op_q[1] ? rt_abs : rs_abs;
                neg_q  <= rs_neg ^ rt_neg;
                rneg_q <= rs_neg;
                div0_q <= (rt_q == '0);
            end
            ST_ITER: begin
                acc  <= acc_next;
                work <= is_div ? {work[XLEN-2:0], q_bit} : {q_bit, work[XLEN-1:1]};
            end
            default: ;
        endcase
    end

    // Architectural state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_FIX) && !flush;
            if (accept && op == MD_MTHI) hi <= rs_val;
            if (accept && op == MD_MTLO) lo <= rs_val;
            if (state == ST_PREP) cnt <= CW'(XLEN - 1);
            if (state == ST_ITER) cnt <= cnt - 1'b1;
            if (state == ST_FIX && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed-vector bench for muldiv_ctrl: products, quotients, corner
// divides, moves, no-op encodings, flush and mid-run reset.
module tb_muldiv_ctrl;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vecs = 0;
    int errs = 0;
    logic [31:0] exp_hi, exp_lo;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        tick(); tick();
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errs++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    // Launches a mul/div and checks latency, hold of HI/LO, result and done pulse.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        tick();
        start = 1'b0;
        vecs++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL %s launch: got busy=%b, expected 1", name, busy);
        end
        for (int n = 1; n <= 34; n++) begin
            tick();
            if (n == 33) begin
                vecs++;
                if (done !== 1'b0 || busy !== 1'b1 || hi !== exp_hi || lo !== exp_lo) begin
                    errs++;
                    $display("FAIL %s hold: got done=%b busy=%b hi=%h lo=%h, expected 0 1 %h %h",
                             name, done, busy, hi, lo, exp_hi, exp_lo);
                end
            end
        end
        exp_hi = eh; exp_lo = el;
        vecs++;
        if (done !== 1'b1 || busy !== 1'b0 || hi !== eh || lo !== el) begin
            errs++;
            $display("FAIL %s result: got done=%b busy=%b hi=%h lo=%h, expected 1 0 %h %h",
                     name, done, busy, hi, lo, eh, el);
        end
        tick();
        vecs++;
        if (done !== 1'b0) begin
            errs++;
            $display("FAIL %s pulse: got done=%b one cycle later, expected 0", name, done);
        end
    endtask

    task automatic do_move(input logic [2:0] o, input logic [31:0] v, input string name);
        start = 1'b1; op = o; rs_val = v;
        tick();
        start = 1'b0;
        if (o == 3'd4) exp_hi = v;
        if (o == 3'd5) exp_lo = v;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            errs++;
            $display("FAIL %s: got busy=%b done=%b hi=%h lo=%h, expected 0 0 %h %h",
                     name, busy, done, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_mult();
        run_op(3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg2x3");
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7xneg3");
        run_op(3'd1, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, "multu_shift");
    endtask

    task automatic test_div();
        run_op(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        run_op(3'd3, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF, "divu_by0");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_wrap");
        run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
        run_op(3'd2, 32'h7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
    endtask

    task automatic test_back_to_back();
        run_op(3'd1, 32'h3, 32'h5, 32'h0, 32'hF, "b2b_first");
        run_op(3'd3, 32'hF, 32'h4, 32'h3, 32'h3, "b2b_second");
    endtask

    task automatic test_noop();
        do_move(3'd6, 32'hCAFE0006, "noop_op6");
        do_move(3'd7, 32'hCAFE0007, "noop_op7");
    endtask

    task automatic test_flush();
        bit saw_done;
        do_move(3'd4, 32'h1234, "mthi_before_flush");
        start = 1'b1; op = 3'd0; rs_val = 32'h5; rt_val = 32'h5;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            if (n == 3) begin
                start = 1'b1; op = 3'd5; rs_val = 32'h55;
            end
            tick();
            start = 1'b0;
        end
        vecs++;
        if (busy !== 1'b1 || lo !== exp_lo) begin
            errs++;
            $display("FAIL start_while_busy: got busy=%b lo=%h, expected 1 %h", busy, lo, exp_lo);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h1234 || lo !== exp_lo) begin
            errs++;
            $display("FAIL flush: got busy=%b done=%b hi=%h lo=%h, expected 0 0 00001234 %h",
                     busy, done, hi, lo, exp_lo);
        end
        saw_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        vecs++;
        if (saw_done || hi !== 32'h1234) begin
            errs++;
            $display("FAIL flush_quiet: got stray done/busy=%b hi=%h, expected 0 00001234", saw_done, hi);
        end
    endtask

    task automatic test_flush_priority();
        flush = 1'b1; start = 1'b1; op = 3'd5; rs_val = 32'h77;
        tick();
        flush = 1'b0; start = 1'b0;
        vecs++;
        if (busy !== 1'b0 || lo !== exp_lo) begin
            errs++;
            $display("FAIL flush_priority_move: got busy=%b lo=%h, expected 0 %h", busy, lo, exp_lo);
        end
        flush = 1'b1; start = 1'b1; op = 3'd0; rs_val = 32'h2; rt_val = 32'h2;
        tick();
        flush = 1'b0; start = 1'b0;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL flush_priority_mul: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_iter();
        bit saw_busy;
        start = 1'b1; op = 3'd1; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 12; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        vecs++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errs++;
            $display("FAIL reset_mid_iter: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0",
                     busy, done, hi, lo);
        end
        do_move(3'd5, 32'hAA, "mtlo_after_reset");
        saw_busy = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) saw_busy = 1'b1;
        end
        vecs++;
        if (saw_busy || lo !== 32'hAA) begin
            errs++;
            $display("FAIL post_reset_quiet: got stray busy/done=%b lo=%h, expected 0 000000aa", saw_busy, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        do_move(3'd4, 32'h0BADF00D, "mthi");
        do_move(3'd5, 32'h600DCAFE, "mtlo");
        test_noop();
        test_flush();
        test_flush_priority();
        test_reset_mid_iter();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the operand and HI/LO width; all values below assume 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to launch the operation on op.
REQ-005 SHALL have port op  input  3  operation select: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have port rs_val  input  XLEN  first operand (dividend, multiplicand, MTHI/MTLO source).
REQ-007 SHALL have port rt_val  input  XLEN  second operand (divisor, multiplier).
REQ-008 SHALL have port flush  input  1  cancel any in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; datapath stalls MFHI/MFLO/mul/div issue on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse when HI/LO were updated by a mul/div.
REQ-011 SHALL have port hi  output  XLEN  architectural HI register.
REQ-012 SHALL have port lo  output  XLEN  architectural LO register.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, ITER, FIX; busy = (state != IDLE).
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored with no side effect.
REQ-015 SHALL, on accepted MULT/MULTU/DIV/DIVU, go IDLE->PREP; PREP latches operands, takes absolute values for signed ops, records result signs.
REQ-016 SHALL run ITER for exactly 32 cycles (5-bit counter, 31 down to 0), one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle, then go to FIX.
REQ-017 SHALL in FIX apply sign correction, write hi/lo on the edge leaving FIX, go to IDLE, and drive done=1 for exactly the following cycle.
REQ-018 SHALL give a fixed latency: start sampled at edge 0 -> done high and new hi/lo visible in cycle 35 (34 cycles), independent of operand values.
REQ-019 SHALL produce for MULT/MULTU {hi,lo} = full 64-bit signed/unsigned product.
REQ-020 SHALL produce for DIV/DIVU lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-021 SHALL, for divisor 0 (DIV or DIVU), produce lo=0xFFFFFFFF, hi=rs_val, no exception, same latency.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0 (wrap, no exception).
REQ-023 SHALL execute MTHI/MTLO accepted in IDLE in one cycle: hi (or lo) = rs_val at the accepting edge; busy stays 0, done stays 0.
REQ-024 SHALL treat op encodings 6 and 7 as no-ops when started (no state change).
REQ-025 SHALL, on flush in any non-IDLE state, return to IDLE next edge with hi/lo unchanged and no done pulse.
REQ-026 SHALL give flush priority over start when both are high in IDLE: start dropped.
REQ-027 SHALL keep hi/lo stable at all times except at the FIX-exit edge, MTHI/MTLO edge, or reset.

Reset
REQ-028 SHALL, when rst is high at an edge, force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, regardless of state (including mid-ITER) and overriding start/flush.
REQ-029 SHALL require no reset of internal operand/accumulator registers beyond making them unobservable.

Structure
REQ-030 SHALL place op encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5) and state encodings in the shared defines header used by the ALU op codes.
REQ-031 SHALL factor the per-cycle step into one sub-module muldiv_step (combinational: accumulator, operand, mode -> next accumulator, next quotient bit); the FSM, counter, sign fixup and HI/LO live in muldiv_ctrl.

Verification
REQ-032 SHALL cover MULT rs=0xFFFFFFFE, rt=3 -> done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 SHALL cover MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL cover DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-035 SHALL cover flush at cycle 10 of a MULT after MTHI 0x1234 -> busy low next cycle, no done, hi=0x1234; start during busy ignored.
REQ-036 SHALL cover rst asserted mid-ITER -> next cycle busy=0, done=0, hi=lo=0; later MTLO 0xAA -> lo=0xAA next cycle, busy never rises.
